// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host port: FSM states, frame size,
// common device response codes and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_INH,
    ST_TX_BITS,
    ST_TX_ACK,
    ST_TX_WAIT
  } ps2_state_t;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] ACK    = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;
  localparam logic [7:0] BAT_OK = 8'hAA;

  // Parity bit that makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous show-ahead byte FIFO for received PS/2 bytes, with fill level
// and a one-cycle pulse when a push is dropped because the FIFO is full.
module ps2_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    pop,
  output logic [7:0]              head,
  output logic                    not_empty,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign not_empty = (level != '0);
  assign full      = (level == (PW+1)'(DEPTH));
  assign do_pop    = pop && not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push   = push && (!full || do_pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push && !do_push;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_host_ctrl.sv
// Fully synchronous PS/2 host port: filtered line sampling, device frame
// reception into a byte FIFO, and host command transmission with ACK check.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 2000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  inout  wire                          ps2_clk,
  inout  wire                          ps2_data,
  input  logic                         tx_valid,
  input  logic [7:0]                   tx_byte,
  output logic                         tx_ready,
  output logic                         tx_done,
  output logic                         tx_err,
  output logic                         rx_valid,
  output logic [7:0]                   rx_byte,
  input  logic                         rx_ready,
  output logic                         rx_err,
  output logic                         rx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TMR_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int TW          = $clog2(TMR_MAX + 1);
  localparam int FW          = $clog2(FILTER_LEN + 1);

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] filt_cnt_q [2];
  logic          clk_prev_q;
  logic          clk_f, data_f, fall, rx_start, timed_out;

  ps2_state_t state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          clk_low_q, clk_low_d, data_low_q, data_low_d;
  logic          push, rx_err_d, tx_done_d, tx_err_d;

  assign ps2_clk  = clk_low_q  ? 1'b0 : 1'bz;
  assign ps2_data = data_low_q ? 1'b0 : 1'bz;

  assign clk_f     = filt_q[0];
  assign data_f    = filt_q[1];
  assign fall      = clk_prev_q && !clk_f;
  assign rx_start  = fall && !data_f;
  assign tx_ready  = (state_q == ST_IDLE) && !rx_start;
  assign timed_out = (tmr_q == TW'(TIMEOUT_CYC - 1)) && !fall;

  // A line level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) filt_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= {ps2_data, ps2_clk};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          filt_cnt_q[i] <= '0;
        end else if (filt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i]     <= sync2_q[i];
          filt_cnt_q[i] <= '0;
        end else begin
          filt_cnt_q[i] <= filt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tmr_q      <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      rx_err     <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tmr_q      <= tmr_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      rx_err     <= rx_err_d;
      tx_done    <= tx_done_d;
      tx_err     <= tx_err_d;
    end
  end

  // The 9-bit shifter holds {parity, data} for both directions; TX shifts in
  // ones so the tenth fall naturally releases data as the stop bit.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tmr_d      = tmr_q;
    clk_low_d  = 1'b0;
    data_low_d = data_low_q;
    push       = 1'b0;
    rx_err_d   = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_d      = '0;
        bit_cnt_d  = '0;
        data_low_d = 1'b0;
        if (rx_start) begin
          state_d = ST_RX;
        end else if (tx_valid) begin
          shift_d   = {odd_parity(tx_byte), tx_byte};
          clk_low_d = 1'b1;
          state_d   = ST_TX_INH;
        end
      end
      ST_RX: begin
        tmr_d = fall ? '0 : tmr_q + 1'b1;
        if (fall) begin
          if (bit_cnt_q == 4'(FRAME_BITS - 2)) begin
            if (data_f && ^shift_q) push = 1'b1;
            else                    rx_err_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            shift_d   = {data_f, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (timed_out) begin
          rx_err_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_TX_INH: begin
        clk_low_d = 1'b1;
        tmr_d     = tmr_q + 1'b1;
        if (tmr_q == TW'(INHIBIT_CYC - 1)) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b1;
          tmr_d      = '0;
          bit_cnt_d  = '0;
          state_d    = ST_TX_BITS;
        end
      end
      ST_TX_BITS: begin
        tmr_d = fall ? '0 : tmr_q + 1'b1;
        if (fall) begin
          data_low_d = ~shift_q[0];
          shift_d    = {1'b1, shift_q[8:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'(FRAME_BITS - 2)) state_d = ST_TX_ACK;
        end else if (timed_out) begin
          tx_err_d   = 1'b1;
          data_low_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_TX_ACK: begin
        tmr_d = fall ? '0 : tmr_q + 1'b1;
        if (fall) begin
          if (!data_f) tx_done_d = 1'b1;
          else         tx_err_d  = 1'b1;
          state_d = ST_TX_WAIT;
        end else if (timed_out) begin
          tx_err_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_TX_WAIT: begin
        tmr_d = fall ? '0 : tmr_q + 1'b1;
        if (clk_f && data_f) begin
          state_d = ST_IDLE;
        end else if (timed_out) begin
          tx_err_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        data_low_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  ps2_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(shift_q[7:0]),
    .pop      (rx_ready),
    .head     (rx_byte),
    .not_empty(rx_valid),
    .overflow (rx_overflow),
    .level    (fifo_level)
  );

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Self-checking bench for ps2_host_ctrl: a behavioural PS/2 device drives and
// samples the open-drain lines while a queue model tracks the expected FIFO.
module tb_ps2_host_ctrl;

  localparam int CLK_HZ      = 2_000_000;
  localparam int FIFO_DEPTH  = 8;
  localparam int FILTER_LEN  = 4;
  localparam int INHIBIT_US  = 100;
  localparam int TIMEOUT_US  = 2000;
  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int H           = 20;

  logic       clk, rst_n, tx_valid, rx_ready;
  logic [7:0] tx_byte, rx_byte;
  logic       tx_ready, tx_done, tx_err, rx_valid, rx_err, rx_overflow;
  logic [3:0] fifo_level;
  logic       dev_clk_low, dev_data_low;
  wire        ps2_clk, ps2_data;

  int vectors = 0;
  int miscompares = 0;
  int cnt_rx_err = 0, cnt_rx_ovf = 0, cnt_tx_done = 0, cnt_tx_err = 0;

  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_data);

  ps2_host_ctrl #(
    .CLK_HZ(CLK_HZ), .FIFO_DEPTH(FIFO_DEPTH), .FILTER_LEN(FILTER_LEN),
    .INHIBIT_US(INHIBIT_US), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_err(rx_err),
    .rx_overflow(rx_overflow), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every high cycle of a pulse output is counted, so a stuck pulse shows up.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_err)      cnt_rx_err++;
      if (rx_overflow) cnt_rx_ovf++;
      if (tx_done)     cnt_tx_done++;
      if (tx_err)      cnt_tx_err++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic device_send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (($countones(b) % 2) == 0) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_data_low = ~f[i];
      wait_cycles(H);
      dev_clk_low = 1'b1;
      wait_cycles(H);
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
    wait_cycles(H);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic device_receive(input bit ack, output int inh, output logic [10:0] bits, output bit ok);
    int guard;
    inh = 0;
    ok = 1'b1;
    bits = '0;
    guard = 0;
    while (ps2_clk !== 1'b0 && guard < 50) begin @(negedge clk); guard++; end
    while (ps2_clk === 1'b0 && inh < 4 * INHIBIT_CYC) begin inh++; @(negedge clk); end
    guard = 0;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      ok = 1'b0;
      return;
    end
    bits[0] = ps2_data;
    for (int i = 1; i <= 10; i++) begin
      wait_cycles(H);
      dev_clk_low = 1'b1;
      wait_cycles(H);
      dev_clk_low = 1'b0;
      wait_cycles(2);
      bits[i] = ps2_data;
    end
    wait_cycles(H - 2);
    dev_data_low = ack;
    wait_cycles(H);
    dev_clk_low = 1'b1;
    wait_cycles(H);
    dev_clk_low = 1'b0;
    wait_cycles(H);
    dev_data_low = 1'b0;
    wait_cycles(4 * H);
  endtask

  task automatic test_tx(input logic [7:0] b, input bit ack);
    int d0, e0, inh;
    logic [10:0] bits, exp_bits;
    bit ok;
    d0 = cnt_tx_done;
    e0 = cnt_tx_err;
    exp_bits = {1'b1, ($countones(b) % 2) == 0, b, 1'b0};
    @(negedge clk);
    check("tx_ready_idle", int'(tx_ready), 1);
    tx_byte  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_busy", int'(tx_ready), 0);
    device_receive(ack, inh, bits, ok);
    check("tx_start_seen", int'(ok), 1);
    check("tx_inhibit_long_enough", int'(inh >= INHIBIT_CYC), 1);
    check("tx_frame_bits", int'(bits), int'(exp_bits));
    check("tx_done_pulses", cnt_tx_done - d0, ack ? 1 : 0);
    check("tx_err_pulses", cnt_tx_err - e0, ack ? 0 : 1);
    check("tx_ready_after", int'(tx_ready), 1);
    check("tx_clk_released", int'(ps2_clk), 1);
    check("tx_data_released", int'(ps2_data), 1);
  endtask

  task automatic test_reset();
    check("reset_tx_ready", int'(tx_ready), 1);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_level", int'(fifo_level), 0);
    check("reset_pulses", int'({tx_done, tx_err, rx_err, rx_overflow}), 0);
    check("reset_clk_z", int'(ps2_clk), 1);
    check("reset_data_z", int'(ps2_data), 1);
  endtask

  task automatic test_rx_good();
    int e0 = cnt_rx_err;
    device_send(8'h1C, 1'b0, 11);
    check("rx_good_valid", int'(rx_valid), 1);
    check("rx_good_byte", int'(rx_byte), 'h1C);
    check("rx_good_level", int'(fifo_level), 1);
    check("rx_good_no_err", cnt_rx_err - e0, 0);
    pop_one();
    check("rx_good_popped", int'(rx_valid), 0);
  endtask

  task automatic test_rx_parity();
    int e0 = cnt_rx_err;
    device_send(8'h15, 1'b1, 11);
    check("rx_parity_err", cnt_rx_err - e0, 1);
    check("rx_parity_level", int'(fifo_level), 0);
  endtask

  task automatic test_overflow();
    logic [7:0] model[$];
    logic [7:0] b;
    int o0 = cnt_rx_ovf;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      if (model.size() < FIFO_DEPTH) model.push_back(b);
      device_send(b, 1'b0, 11);
    end
    check("ovf_level", int'(fifo_level), FIFO_DEPTH);
    check("ovf_pulses", cnt_rx_ovf - o0, 1);
    check("ovf_head_first", int'(rx_byte), int'(model[0]));
    while (model.size() > 0) begin
      check("ovf_drain_byte", int'(rx_byte), int'(model.pop_front()));
      pop_one();
    end
    check("ovf_drained", int'(rx_valid), 0);
  endtask

  task automatic test_timeout();
    int e0 = cnt_rx_err;
    device_send(8'($urandom_range(0, 255)), 1'b0, 5);
    wait_cycles(TIMEOUT_CYC + 100);
    check("timeout_rx_err", cnt_rx_err - e0, 1);
    check("timeout_level", int'(fifo_level), 0);
    device_send(8'hAA, 1'b0, 11);
    check("after_timeout_valid", int'(rx_valid), 1);
    check("after_timeout_byte", int'(rx_byte), 'hAA);
    pop_one();
  endtask

  task automatic test_random_rx();
    logic [7:0] model[$];
    logic [7:0] b;
    bit bad, exp_ovf;
    int e0, o0, k;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      exp_ovf = 1'b0;
      e0 = cnt_rx_err;
      o0 = cnt_rx_ovf;
      device_send(b, bad, 11);
      if (!bad) begin
        if (model.size() < FIFO_DEPTH) model.push_back(b);
        else exp_ovf = 1'b1;
      end
      check("rand_err", cnt_rx_err - e0, bad ? 1 : 0);
      check("rand_ovf", cnt_rx_ovf - o0, exp_ovf ? 1 : 0);
      check("rand_level", int'(fifo_level), model.size());
      k = $urandom_range(0, model.size());
      for (int j = 0; j < k; j++) begin
        check("rand_byte", int'(rx_byte), int'(model.pop_front()));
        pop_one();
      end
    end
    while (model.size() > 0) begin
      check("rand_drain_byte", int'(rx_byte), int'(model.pop_front()));
      pop_one();
    end
  endtask

  task automatic test_reset_mid_tx();
    int guard, d0, e0;
    d0 = cnt_tx_done;
    e0 = cnt_tx_err;
    @(negedge clk);
    tx_byte  = 8'hF4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_cycles(20);
    @(negedge clk);
    check("mid_inh_clk_low", int'(ps2_clk), 0);
    #2 rst_n = 1'b0;
    #1 check("mid_inh_clk_released", int'(ps2_clk), 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    guard = 0;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && guard < 2 * INHIBIT_CYC) begin
      @(negedge clk);
      guard++;
    end
    check("mid_bits_start_seen", int'(ps2_data), 0);
    #2 rst_n = 1'b0;
    #1 check("mid_bits_data_released", int'(ps2_data), 1);
    check("mid_bits_clk_released", int'(ps2_clk), 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(10);
    check("mid_no_pulses", (cnt_tx_done - d0) + (cnt_tx_err - e0), 0);
    check("mid_tx_ready", int'(tx_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    tx_valid = 1'b0;
    tx_byte = '0;
    rx_ready = 1'b0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    #3 rst_n = 1'b0;
    wait_cycles(5);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(20);
    @(negedge clk);
    test_reset();
    test_rx_good();
    test_rx_parity();
    test_tx(8'hED, 1'b1);
    test_tx(8'hED, 1'b0);
    test_tx(8'($urandom_range(0, 255)), 1'b1);
    test_overflow();
    test_timeout();
    test_random_rx();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
